// File: rtl/ms_path_checker.sv
// rtl/ms_path_checker.sv - checks a maze solver's emitted path against the snooped maze bitstream
// Optional macro MS_PATH_CHECKER_REVISIT_EN adds a visited bitmap and REVISIT (code 5) detection.
module ms_path_checker #(
    parameter int DIM     = 15,
    parameter int TIMEOUT = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       maze,
    input  logic       path_valid,
    input  logic [3:0] path_x,
    input  logic [3:0] path_y,
    input  logic       path_none,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_code,
    output logic [7:0] step_count
);
    localparam int CELLS = DIM * DIM;
    localparam int LW    = $clog2(CELLS);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [3:0] START_C = 4'd1;
    localparam logic [3:0] GOAL_C  = 4'(DIM - 2);

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_START   = 3'd1;
    localparam logic [2:0] E_STEP    = 3'd2;
    localparam logic [2:0] E_WALL    = 3'd3;
    localparam logic [2:0] E_END     = 3'd4;
    localparam logic [2:0] E_REVISIT = 3'd5;
    localparam logic [2:0] E_NOPATH  = 3'd6;
    localparam logic [2:0] E_TIMEOUT = 3'd7;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_PATH, CHECK} state_t;

    state_t            state;
    logic [CELLS-1:0]  map;
    logic [LW-1:0]     load_cnt;
    logic [TW-1:0]     tcnt;
    logic [3:0]        prev_x;
    logic [3:0]        prev_y;

    logic              in_range;
    logic [LW-1:0]     cell_idx;
    logic              cell_wall;
    logic              revisit_hit;
    logic [3:0]        dx;
    logic [3:0]        dy;
    logic              adjacent;
    logic [2:0]        coord_err;
    logic [2:0]        pv_err;
    logic [2:0]        final_code;

`ifdef MS_PATH_CHECKER_REVISIT_EN
    logic [CELLS-1:0]  visited;
`endif

    always_comb begin
        in_range  = (path_x < 4'(DIM)) && (path_y < 4'(DIM));
        cell_idx  = LW'(path_y) * LW'(DIM) + LW'(path_x);
        cell_wall = in_range ? map[cell_idx] : 1'b1;
`ifdef MS_PATH_CHECKER_REVISIT_EN
        revisit_hit = in_range ? visited[cell_idx] : 1'b0;
`else
        revisit_hit = 1'b0;
`endif
        dx       = (path_x >= prev_x) ? path_x - prev_x : prev_x - path_x;
        dy       = (path_y >= prev_y) ? path_y - prev_y : prev_y - path_y;
        adjacent = ({1'b0, dx} + {1'b0, dy}) == 5'd1;

        // Per-coordinate priority: START/STEP, then WALL, then REVISIT.
        coord_err = E_NONE;
        if (state == WAIT_PATH) begin
            if (path_x != START_C || path_y != START_C)
                coord_err = E_START;
        end else if (!adjacent) begin
            coord_err = E_STEP;
        end
        if (coord_err == E_NONE) begin
            if (cell_wall)
                coord_err = E_WALL;
            else if (revisit_hit)
                coord_err = E_REVISIT;
        end
        pv_err = path_none ? E_NOPATH : coord_err;

        if (fail_code != E_NONE)
            final_code = fail_code;
        else if (path_none)
            final_code = E_NOPATH;
        else if (prev_x != GOAL_C || prev_y != GOAL_C)
            final_code = E_END;
        else
            final_code = E_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            map        <= '1;
            load_cnt   <= '0;
            tcnt       <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_code  <= E_NONE;
            step_count <= '0;
`ifdef MS_PATH_CHECKER_REVISIT_EN
            visited    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        map[0]     <= maze;
                        load_cnt   <= LW'(1);
                        pass       <= 1'b0;
                        fail_code  <= E_NONE;
                        step_count <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        map[load_cnt] <= maze;
                        load_cnt      <= load_cnt + LW'(1);
                        if (load_cnt == LW'(CELLS - 1)) begin
                            tcnt  <= '0;
                            state <= WAIT_PATH;
`ifdef MS_PATH_CHECKER_REVISIT_EN
                            visited <= '0;
`endif
                        end
                    end
                end
                WAIT_PATH: begin
                    if (path_valid) begin
                        step_count <= 8'd1;
                        fail_code  <= pv_err;
                        prev_x     <= path_x;
                        prev_y     <= path_y;
                        state      <= CHECK;
`ifdef MS_PATH_CHECKER_REVISIT_EN
                        if (in_range) visited[cell_idx] <= 1'b1;
`endif
                    end else if (path_none) begin
                        done       <= 1'b1;
                        pass       <= 1'b0;
                        fail_code  <= E_NOPATH;
                        step_count <= '0;
                        state      <= IDLE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_code <= E_TIMEOUT;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                CHECK: begin
                    if (path_valid) begin
                        if (step_count != 8'hFF) step_count <= step_count + 8'd1;
                        if (fail_code == E_NONE) fail_code <= pv_err;
                        prev_x <= path_x;
                        prev_y <= path_y;
`ifdef MS_PATH_CHECKER_REVISIT_EN
                        if (in_range) visited[cell_idx] <= 1'b1;
`endif
                    end else begin
                        done      <= 1'b1;
                        pass      <= (final_code == E_NONE);
                        fail_code <= final_code;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ms_path_checker.sv
// tb/tb_ms_path_checker.sv - directed table and randomized checks of ms_path_checker against a path model
module tb_ms_path_checker;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       maze;
    logic       path_valid;
    logic [3:0] path_x;
    logic [3:0] path_y;
    logic       path_none;
    logic       done;
    logic       pass;
    logic [2:0] fail_code;
    logic [7:0] step_count;

    int checks = 0;
    int errors = 0;

    logic [224:0] cur_maze;
    int qx[$];
    int qy[$];

    typedef struct {
        string      name;
        int         kind;
        int         none_at;
        logic       exp_pass;
        logic [2:0] exp_code;
        int         exp_steps;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ms_path_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .maze(maze),
        .path_valid(path_valid), .path_x(path_x), .path_y(path_y), .path_none(path_none),
        .done(done), .pass(pass), .fail_code(fail_code), .step_count(step_count)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [224:0] corridor_maze();
        logic [224:0] m = '1;
        for (int y = 1; y <= 13; y++) m[y * 15 + 1] = 1'b0;
        for (int x = 1; x <= 13; x++) m[13 * 15 + x] = 1'b0;
        return m;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: walk the coordinate list applying the path rules, first error wins.
    function automatic void model(input int none_at, output logic exp_pass,
                                  output logic [2:0] exp_code, output int exp_steps);
        bit seen[int];
        int code = 0;
        for (int i = 0; i < qx.size(); i++) begin
            int x = qx[i];
            int y = qy[i];
            int e = 0;
            if (i == none_at && code == 0) code = 6;
            if (i == 0 && !(x == 1 && y == 1)) e = 1;
            else if (i > 0 && iabs(x - qx[i-1]) + iabs(y - qy[i-1]) != 1) e = 2;
            else if (x > 14 || y > 14 || cur_maze[y * 15 + x]) e = 3;
`ifdef MS_PATH_CHECKER_REVISIT_EN
            else if (seen.exists(y * 15 + x)) e = 5;
`endif
            if (code == 0) code = e;
            if (x <= 14 && y <= 14) seen[y * 15 + x] = 1'b1;
        end
        if (code == 0 && (qx[qx.size()-1] != 13 || qy[qy.size()-1] != 13)) code = 4;
        exp_code  = 3'(code);
        exp_pass  = (code == 0);
        exp_steps = (qx.size() > 255) ? 255 : qx.size();
    endfunction

    task automatic load_maze(input logic [224:0] m, input bit gaps, input int stop_at);
        cur_maze = m;
        for (int k = 0; k < 225 && k < stop_at; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    maze     = 1'($urandom);
                end
            end
            @(negedge clk);
            if (k == 1)
                check("load_clears_result", {pass, fail_code, step_count}, 32'd0);
            in_valid = 1'b1;
            maze     = m[k];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic void legal_path();
        qx.delete();
        qy.delete();
        for (int y = 1; y <= 13; y++) begin qx.push_back(1); qy.push_back(y); end
        for (int x = 2; x <= 13; x++) begin qx.push_back(x); qy.push_back(13); end
    endfunction

    function automatic void build_path(input int kind);
        legal_path();
        case (kind)
            1: begin qx[0] = 1; qy[0] = 2; end
            2: begin
                qx.delete(5); qy.delete(5);
                for (int i = 0; i < qx.size(); i++)
                    if (qx[i] == 6 && qy[i] == 13) qy[i] = 12;
            end
            3: begin qx.delete(qx.size() - 1); qy.delete(qy.size() - 1); end
            4: begin
                qx.insert(2, 2); qy.insert(2, 2);
                qx.insert(3, 1); qy.insert(3, 2);
            end
            5: begin
                qx.insert(2, 1); qy.insert(2, 1);
                qx.insert(3, 1); qy.insert(3, 2);
            end
            6: begin
                qx.delete(); qy.delete();
                for (int i = 0; i < 300; i++) begin qx.push_back(1); qy.push_back(1 + (i % 2)); end
            end
            default: ;
        endcase
    endfunction

    task automatic run_path(input string name, input int none_at, output logic got_pass,
                            output logic [2:0] got_code, output int got_steps);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int i = 0; i < qx.size(); i++) begin
            @(negedge clk);
            path_valid = 1'b1;
            path_x     = 4'(qx[i]);
            path_y     = 4'(qy[i]);
            path_none  = (i == none_at);
        end
        @(negedge clk);
        check({name, "_no_early_done"}, done, 1'b0);
        path_valid = 1'b0;
        path_none  = 1'b0;
        path_x     = 4'($urandom);
        path_y     = 4'($urandom);
        @(negedge clk);
        check({name, "_done_after_fall"}, done, 1'b1);
        got_pass  = pass;
        got_code  = fail_code;
        got_steps = int'(step_count);
        @(negedge clk);
        check({name, "_done_one_cycle"}, done, 1'b0);
        check({name, "_result_holds"}, {pass, fail_code, step_count}, {got_pass, got_code, 8'(got_steps)});
    endtask

    task automatic compare(input string name, input logic gp, input logic [2:0] gc, input int gs,
                           input logic ep, input logic [2:0] ec, input int es);
        check({name, "_pass"}, gp, ep);
        check({name, "_code"}, gc, ec);
        check({name, "_steps"}, gs, es);
    endtask

    initial begin
        logic       gp, ep;
        logic [2:0] gc, ec;
        int         gs, es, cnt;
        logic [224:0] m;

        rst = 1'b1; in_valid = 1'b0; maze = 1'b0;
        path_valid = 1'b0; path_x = '0; path_y = '0; path_none = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {done, pass, fail_code, step_count}, 32'd0);
        rst = 1'b0;

        vecs.push_back('{"legal",     0, -1, 1'b1, 3'd0, 25});
        vecs.push_back('{"start",     1, -1, 1'b0, 3'd1, 25});
        vecs.push_back('{"jump",      2, -1, 1'b0, 3'd2, 24});
        vecs.push_back('{"end",       3, -1, 1'b0, 3'd4, 24});
        vecs.push_back('{"wall",      4, -1, 1'b0, 3'd3, 27});
`ifdef MS_PATH_CHECKER_REVISIT_EN
        vecs.push_back('{"revisit",   5, -1, 1'b0, 3'd5, 27});
        vecs.push_back('{"saturate",  6, -1, 1'b0, 3'd5, 255});
`else
        vecs.push_back('{"revisit",   5, -1, 1'b1, 3'd0, 27});
        vecs.push_back('{"saturate",  6, -1, 1'b0, 3'd4, 255});
`endif
        vecs.push_back('{"none_first", 0, 0, 1'b0, 3'd6, 25});
        vecs.push_back('{"none_mid",  0, 10, 1'b0, 3'd6, 25});

        foreach (vecs[i]) begin
            load_maze(corridor_maze(), 1'b1, 225);
            build_path(vecs[i].kind);
            run_path(vecs[i].name, vecs[i].none_at, gp, gc, gs);
            compare(vecs[i].name, gp, gc, gs, vecs[i].exp_pass, vecs[i].exp_code, vecs[i].exp_steps);
        end

        // path_none alone in WAIT_PATH
        load_maze(corridor_maze(), 1'b0, 225);
        @(negedge clk);
        path_none = 1'b1;
        @(negedge clk);
        path_none = 1'b0;
        check("nopath_done", done, 1'b1);
        check("nopath_result", {pass, fail_code, step_count}, {1'b0, 3'd6, 8'd0});
        @(negedge clk);
        check("nopath_done_pulse", done, 1'b0);

        // Timeout with in_valid noise that must be ignored in WAIT_PATH
        load_maze(corridor_maze(), 1'b0, 225);
        cnt = 0;
        while (cnt < 5000) begin
            @(negedge clk);
            cnt++;
            if (done) break;
            in_valid = 1'($urandom);
        end
        in_valid = 1'b0;
        check("timeout_done_seen", done, 1'b1);
        check("timeout_latency_ok", (cnt >= 4094 && cnt <= 4096), 1'b1);
        check("timeout_result", {pass, fail_code}, {1'b0, 3'd7});

        // Async reset while holding a failing result, then mid-load at bit 100
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_clears_result", {done, pass, fail_code, step_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load_maze(corridor_maze(), 1'b0, 100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_maze(corridor_maze(), 1'b1, 225);
        legal_path();
        run_path("reload", -1, gp, gc, gs);
        model(-1, ep, ec, es);
        compare("reload", gp, gc, gs, ep, ec, es);

        // Randomized mazes and paths against the model
        for (int it = 0; it < 30; it++) begin
            m = corridor_maze();
            for (int k = 0; k < 225; k++)
                if ($urandom_range(0, 2) == 0) m[k] = 1'b0;
            load_maze(m, 1'b1, 225);
            if ($urandom_range(0, 1) == 0) begin
                legal_path();
                if ($urandom_range(0, 1) == 0) begin
                    int j = $urandom_range(0, qx.size() - 1);
                    qx[j] = $urandom_range(0, 15);
                    qy[j] = $urandom_range(0, 15);
                end
                if ($urandom_range(0, 3) == 0) begin
                    qx.delete(qx.size() - 1); qy.delete(qy.size() - 1);
                end
            end else begin
                int x = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : 1;
                int y = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : 1;
                int len = $urandom_range(1, 40);
                qx.delete(); qy.delete();
                for (int i = 0; i < len; i++) begin
                    qx.push_back(x); qy.push_back(y);
                    case ($urandom_range(0, 4))
                        0: x = (x + 1) % 16;
                        1: x = (x + 15) % 16;
                        2: y = (y + 1) % 16;
                        3: y = (y + 15) % 16;
                        default: begin x = $urandom_range(0, 15); y = $urandom_range(0, 15); end
                    endcase
                end
            end
            run_path("random", -1, gp, gc, gs);
            model(-1, ep, ec, es);
            compare($sformatf("random%0d", it), gp, gc, gs, ep, ec, es);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
